// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle add/subtract processing DIGIT bits per clock, LSB digit first.
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             r_in,
  output logic [WIDTH-1:0] s,
  output logic             r_out,
  output logic             ovf,
  output logic             busy,
  output logic             done
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_q, b_q;
  logic             c;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] ad, bd;
  logic [DIGIT:0]   sum;
  logic             last, accept;
  assign ad     = a_q[cnt*DIGIT +: DIGIT];
  assign bd     = b_q[cnt*DIGIT +: DIGIT];
  assign sum    = {1'b0, ad} + {1'b0, bd} + {{DIGIT{1'b0}}, c};
  assign last   = cnt == CW'(N - 1);
  assign accept = start && state != RUN;
  assign busy   = state == RUN;
  assign done   = state == DONE;
  always_comb begin
    state_n = accept ? RUN : (state == RUN && !last) ? RUN : (state == RUN) ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      r_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_q <= a;
      b_q <= sub ? ~b : b;
      c   <= r_in ^ sub;
      cnt <= '0;
      s   <= '0;
    end else if (busy) begin
      s[cnt*DIGIT +: DIGIT] <= sum[DIGIT-1:0];
      c   <= sum[DIGIT];
      cnt <= cnt + CW'(1);
      // carry into the MSB is recovered as a ^ b ^ sum at that bit position
      if (last) begin
        r_out <= sum[DIGIT];
        ovf   <= ad[DIGIT-1] ^ bd[DIGIT-1] ^ sum[DIGIT-1] ^ sum[DIGIT];
      end
    end
  end
endmodule
